// File: rtl/refclk_second_strobe.sv
// refclk_second_strobe: synchronises a 32.768 kHz reference into sysclk,
// pulses once per reference rising edge and once per divided second.
//
// Ports:
//   i_sysclk    system clock, all state on its rising edge
//   i_reset     synchronous active-high reset
//   i_refclk    asynchronous reference oscillator
//   i_en        enables edge counting (0 freezes the counter)
//   i_fast_set  selects FAST_DIV instead of REFCLK_DIV
//   i_clear     synchronously zeroes the edge counter
//   o_ref_stb   one-cycle pulse per synchronised reference rising edge
//   o_sec_stb   one-cycle pulse on the terminal edge of each second
//   o_phase     current edge count within the second
module refclk_second_strobe #(
    parameter int unsigned REFCLK_DIV = 32768,
    parameter int unsigned FAST_DIV   = 256,
    parameter int unsigned CNT_W      = $clog2(REFCLK_DIV)
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_refclk,
    input  logic             i_en,
    input  logic             i_fast_set,
    input  logic             i_clear,
    output logic             o_ref_stb,
    output logic             o_sec_stb,
    output logic [CNT_W-1:0] o_phase
);

    localparam logic [CNT_W-1:0] NORM_LAST = CNT_W'(REFCLK_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    logic             sync0_q;
    logic             sync1_q;
    logic             prev_q;
    logic             ref_stb_q;
    logic             sec_stb_q;
    logic             sec_stb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;
    logic             rise;

    always_comb begin
        rise      = sync1_q & ~prev_q;
        last      = i_fast_set ? FAST_LAST : NORM_LAST;
        cnt_d     = cnt_q;
        sec_stb_d = 1'b0;
        if (i_clear) begin
            cnt_d = '0;
        end else if (rise && i_en) begin
            // >= so a switch to the shorter divisor wraps at once
            if (cnt_q >= last) begin
                cnt_d     = '0;
                sec_stb_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            // preload high: a reference already high at release is not an edge
            sync0_q   <= 1'b1;
            sync1_q   <= 1'b1;
            prev_q    <= 1'b1;
            ref_stb_q <= 1'b0;
            sec_stb_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync0_q   <= i_refclk;
            sync1_q   <= sync0_q;
            prev_q    <= sync1_q;
            ref_stb_q <= rise;
            sec_stb_q <= sec_stb_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_ref_stb = ref_stb_q;
    assign o_sec_stb = sec_stb_q;
    assign o_phase   = cnt_q;

endmodule

// File: tb/tb_refclk_second_strobe.sv
// Self-checking bench for refclk_second_strobe (REFCLK_DIV=8, FAST_DIV=2).
// Directed scenarios plus randomized periods against a behavioural model.
module tb_refclk_second_strobe;

    localparam int NORM = 8;
    localparam int FAST = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refclk = 1'b1;
    logic       en = 1'b0;
    logic       fast = 1'b0;
    logic       clr = 1'b0;
    logic       ref_stb;
    logic       sec_stb;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    refclk_second_strobe #(
        .REFCLK_DIV(NORM),
        .FAST_DIV  (FAST)
    ) dut (
        .i_sysclk  (clk),
        .i_reset   (rst),
        .i_refclk  (refclk),
        .i_en      (en),
        .i_fast_set(fast),
        .i_clear   (clr),
        .o_ref_stb (ref_stb),
        .o_sec_stb (sec_stb),
        .o_phase   (phase)
    );

    // Reference model: edges are seen two samples late; the count of
    // qualified edges reaching the divisor ends the second.
    bit smp [3] = '{1'b1, 1'b1, 1'b1};
    int m_ph = 0;
    bit m_sec = 1'b0;
    bit m_ref = 1'b0;

    always @(posedge clk) begin : ref_model
        int lim;
        int nph;
        bit nsec;
        bit seen;
        seen = smp[1] && !smp[2];
        lim  = fast ? FAST : NORM;
        nph  = m_ph;
        nsec = 1'b0;
        if (clr) begin
            nph = 0;
        end else if (seen && en) begin
            if (m_ph + 1 >= lim) begin
                nph  = 0;
                nsec = 1'b1;
            end else begin
                nph = m_ph + 1;
            end
        end
        if (rst) begin
            smp   <= '{1'b1, 1'b1, 1'b1};
            m_ph  <= 0;
            m_sec <= 1'b0;
            m_ref <= 1'b0;
        end else begin
            smp   <= '{refclk, smp[0], smp[1]};
            m_ph  <= nph;
            m_sec <= nsec;
            m_ref <= seen;
        end
    end

    // One reference period: hi cycles high then lo cycles low.
    // Returns pulse counts, model disagreements, final phase and a
    // snapshot of the outputs three cycles after the rising drive.
    task automatic ref_period(input int hi, input int lo,
                              input int clr_pct, input int clr_at,
                              input int rst_at,
                              output int nref, output int nsec,
                              output int nmis, output int last_ph,
                              output int s_ph, output int s_ref,
                              output int s_sec);
        nref = 0; nsec = 0; nmis = 0; last_ph = 0;
        s_ph = 0; s_ref = 0; s_sec = 0;
        for (int c = 0; c < hi + lo; c++) begin
            @(negedge clk);
            if (ref_stb === 1'b1) nref++;
            if (sec_stb === 1'b1) nsec++;
            if (phase !== 3'(m_ph) || ref_stb !== m_ref ||
                sec_stb !== m_sec) nmis++;
            if (c == 3) begin
                s_ph = int'(phase); s_ref = int'(ref_stb);
                s_sec = int'(sec_stb);
            end
            last_ph = int'(phase);
            refclk = (c < hi);
            clr = (c == clr_at) ||
                  (clr_pct > 0 && $urandom_range(99) < clr_pct);
            rst = (c == rst_at);
        end
    endtask

    task automatic prep();
        @(negedge clk);
        refclk = 1'b0; clr = 1'b1; rst = 1'b0; en = 1'b1; fast = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int nr, ns, nm, lp, sp, sr, ss;
        @(negedge clk);
        rst = 1'b1; refclk = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (phase !== 3'd0 || ref_stb !== 1'b0 || sec_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: phase=%0d ref=%b sec=%b want 0 0 0",
                     phase, ref_stb, sec_stb);
        end
        ref_period(20, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (nr !== 0) begin
            errors++;
            $display("FAIL reset_high_no_edge: ref pulses=%0d want 0", nr);
        end
        ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (nr !== 1 || sr !== 1) begin
            errors++;
            $display("FAIL first_edge: pulses=%0d at3=%0d want 1 1", nr, sr);
        end
        checks++;
        if (nm !== 0) begin
            errors++;
            $display("FAIL first_edge_model: mismatches=%0d want 0", nm);
        end
    endtask

    task automatic test_count();
        int nr, ns, nm, lp, sp, sr, ss, exp_ph, exp_s;
        prep();
        for (int i = 0; i < 16; i++) begin
            ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
            exp_ph = (i + 1) % 8;
            exp_s = (exp_ph == 0) ? 1 : 0;
            checks++;
            if (lp !== exp_ph || ns !== exp_s || nr !== 1) begin
                errors++;
                $display("FAIL count[%0d]: phase=%0d sec=%0d ref=%0d want %0d %0d 1",
                         i, lp, ns, nr, exp_ph, exp_s);
            end
            checks++;
            if (ss !== exp_s || (exp_s == 1 && sr !== 1) || nm !== 0) begin
                errors++;
                $display("FAIL count_align[%0d]: sec@ref=%0d ref=%0d mis=%0d want %0d 1 0",
                         i, ss, sr, nm, exp_s);
            end
        end
    endtask

    task automatic test_fast();
        int nr, ns, nm, lp, sp, sr, ss, exp_ph;
        prep();
        repeat (5) ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (lp !== 5) begin
            errors++;
            $display("FAIL fast_pre: phase=%0d want 5", lp);
        end
        fast = 1'b1;
        ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (ns !== 1 || lp !== 0 || nm !== 0) begin
            errors++;
            $display("FAIL fast_switch: sec=%0d phase=%0d mis=%0d want 1 0 0",
                     ns, lp, nm);
        end
        for (int i = 0; i < 4; i++) begin
            ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
            exp_ph = (i + 1) % 2;
            checks++;
            if (lp !== exp_ph || ns !== (exp_ph == 0 ? 1 : 0)) begin
                errors++;
                $display("FAIL fast_run[%0d]: phase=%0d sec=%0d want %0d",
                         i, lp, ns, exp_ph);
            end
        end
        fast = 1'b0;
    endtask

    task automatic test_enable();
        int nr, ns, nm, lp, sp, sr, ss, tr, ts;
        prep();
        repeat (3) ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        en = 1'b0;
        tr = 0; ts = 0;
        repeat (4) begin
            ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
            tr += nr; ts += ns;
        end
        checks++;
        if (lp !== 3 || ts !== 0 || tr !== 4) begin
            errors++;
            $display("FAIL en_hold: phase=%0d sec=%0d ref=%0d want 3 0 4",
                     lp, ts, tr);
        end
        en = 1'b1;
        ts = 0;
        repeat (4) begin
            ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
            ts += ns;
        end
        ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (ts !== 0 || ns !== 1 || lp !== 0) begin
            errors++;
            $display("FAIL en_resume: early=%0d sec=%0d phase=%0d want 0 1 0",
                     ts, ns, lp);
        end
    endtask

    task automatic test_clear_terminal();
        int nr, ns, nm, lp, sp, sr, ss, ts;
        prep();
        repeat (7) ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (lp !== 7) begin
            errors++;
            $display("FAIL clr_pre: phase=%0d want 7", lp);
        end
        ref_period(10, 10, 0, 2, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (sp !== 0 || ss !== 0 || sr !== 1 || ns !== 0) begin
            errors++;
            $display("FAIL clr_terminal: phase=%0d sec=%0d ref=%0d want 0 0 1",
                     sp, ns, sr);
        end
        ts = 0;
        repeat (7) begin
            ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
            ts += ns;
        end
        ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (ts !== 0 || ns !== 1) begin
            errors++;
            $display("FAIL clr_next: early=%0d sec=%0d want 0 1", ts, ns);
        end
    endtask

    task automatic test_reset_mid();
        int nr, ns, nm, lp, sp, sr, ss;
        prep();
        repeat (6) ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (lp !== 6) begin
            errors++;
            $display("FAIL rst_pre: phase=%0d want 6", lp);
        end
        ref_period(10, 10, 0, -1, 2, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (sp !== 0 || ss !== 0 || sr !== 0 || nr !== 0) begin
            errors++;
            $display("FAIL rst_mid: phase=%0d sec=%0d ref=%0d want 0 0 0",
                     sp, ss, nr);
        end
        repeat (3) ref_period(10, 10, 0, -1, -1, nr, ns, nm, lp, sp, sr, ss);
        checks++;
        if (lp !== 3 || nm !== 0) begin
            errors++;
            $display("FAIL rst_restart: phase=%0d mis=%0d want 3 0", lp, nm);
        end
    endtask

    task automatic test_random();
        int nr, ns, nm, lp, sp, sr, ss;
        prep();
        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(99) < 80);
            fast = $urandom_range(1);
            ref_period($urandom_range(14, 2), $urandom_range(14, 2), 3,
                       -1, -1, nr, ns, nm, lp, sp, sr, ss);
            checks++;
            if (nm !== 0) begin
                errors++;
                $display("FAIL random[%0d]: model mismatches=%0d want 0",
                         i, nm);
            end
        end
        @(negedge clk);
        clr = 1'b0; fast = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_fast();
        test_enable();
        test_clear_terminal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
